// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressed data memory answering one CPU load/store at a time
// Fixed-latency request/response handshake with alignment, range and size error checking.
module dmem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  dbg_byte1
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_mem [DEPTH_BYTES];

  logic        w_accept;
  logic        w_commit;
  logic        w_use_in;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_signed;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_nbytes;
  logic [32:0] w_last;
  logic        w_err;
  logic [AW-1:0] w_idx [4];
  logic [7:0]  w_rbyte [4];
  logic [31:0] w_load;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dbg_byte1  = r_mem[1];
  assign w_accept   = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the live inputs are used.
  assign w_use_in = (r_state == S_IDLE);
  assign w_we     = w_use_in ? req_we     : r_we;
  assign w_size   = w_use_in ? req_size   : r_size;
  assign w_signed = w_use_in ? req_signed : r_signed;
  assign w_addr   = w_use_in ? req_addr   : r_addr;
  assign w_wdata  = w_use_in ? req_wdata  : r_wdata;

  always_comb begin
    case (w_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign w_last = {1'b0, w_addr} + 33'(w_nbytes) - 33'd1;
  assign w_err  = (w_size == 2'b11)
               || ((w_size == 2'b01) && w_addr[0])
               || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
               || (w_last >= 33'(DEPTH_BYTES));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k]   = w_addr[AW-1:0] + AW'(k);
      w_rbyte[k] = r_mem[w_idx[k]];
    end
  end

  always_comb begin
    case (w_size)
      2'b00:   w_load = {{24{w_signed & w_rbyte[0][7]}}, w_rbyte[0]};
      2'b01:   w_load = {{16{w_signed & w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
      default: w_load = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
    endcase
    if (w_err || w_we) w_load = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (w_commit) begin
        r_rdata <= w_load;
        r_err   <= w_err;
      end
      if (w_commit && w_we && !w_err) begin
        r_mem[w_idx[0]] <= w_wdata[7:0];
        if (w_size != 2'b00) r_mem[w_idx[1]] <= w_wdata[15:8];
        if (w_size == 2'b10) begin
          r_mem[w_idx[2]] <= w_wdata[23:16];
          r_mem[w_idx[3]] <= w_wdata[31:24];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
// Instance A runs LATENCY=2, instance B runs LATENCY=4; sel routes stimulus and observation.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_valid, req_we, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [7:0]  a_dbg_byte1;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [7:0]  b_dbg_byte1;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  dbg_byte1;

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_err   = sel ? b_resp_err   : a_resp_err;
  assign resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
  assign dbg_byte1  = sel ? b_dbg_byte1  : a_dbg_byte1;

  dmem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_resp_valid),
    .resp_ready(resp_ready), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .dbg_byte1(a_dbg_byte1)
  );

  dmem_responder #(.DEPTH_BYTES(256), .LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_resp_valid),
    .resp_ready(resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .dbg_byte1(b_dbg_byte1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input string tag, output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // scramble inputs after accept; the response must come from the latched request
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_signed = ~sgn;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    check({tag, " latency"}, 32'(n), 32'(lat));
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_dbg;
  } vec_t;

  vec_t vecs [26];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          pulses;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h004, 32'h1122_3344, 32'h0000_0000, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h1122_3344, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h005, 32'h0,         32'h0000_0033, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h001, 32'h0000_00AB, 32'h0000_0000, 1'b0, 8'hAB};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h001, 32'h0,         32'hFFFF_FFAB, 1'b0, 8'hAB};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h001, 32'h0,         32'h0000_00AB, 1'b0, 8'hAB};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h000, 32'h0,         32'hFFFF_AB00, 1'b0, 8'hAB};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h003, 32'h0,         32'h0000_0000, 1'b1, 8'hAB};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 8'hAB};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 32'h0000_0000, 1'b1, 8'hAB};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h0FC, 32'h0,         32'hCAFE_F00D, 1'b0, 8'hAB};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h0FE, 32'h0,         32'h0000_CAFE, 1'b0, 8'hAB};
    vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h0FE, 32'h0,         32'hFFFF_CAFE, 1'b0, 8'hAB};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,         32'h0000_0000, 1'b1, 8'hAB};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0,         32'h0000_0000, 1'b1, 8'hAB};
    vecs[15] = '{1'b1, 2'd0, 1'b0, 32'h006, 32'hFFFF_FF55, 32'h0000_0000, 1'b0, 8'hAB};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h1155_3344, 1'b0, 8'hAB};
    vecs[17] = '{1'b1, 2'd1, 1'b0, 32'h002, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 8'hAB};
    vecs[18] = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,         32'hBEEF_AB00, 1'b0, 8'hAB};
    vecs[19] = '{1'b1, 2'd1, 1'b0, 32'h005, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 8'hAB};
    vecs[20] = '{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h1155_3344, 1'b0, 8'hAB};
    vecs[21] = '{1'b0, 2'd0, 1'b1, 32'h0FF, 32'h0,         32'hFFFF_FFCA, 1'b0, 8'hAB};
    vecs[22] = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,         32'h0000_0000, 1'b1, 8'hAB};
    vecs[23] = '{1'b1, 2'd0, 1'b0, 32'h0FF, 32'h0000_0077, 32'h0000_0000, 1'b0, 8'hAB};
    vecs[24] = '{1'b0, 2'd0, 1'b0, 32'h0FF, 32'h0,         32'h0000_0077, 1'b0, 8'hAB};
    vecs[25] = '{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,   32'h0000_0000, 1'b1, 8'hAB};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0;
    resp_ready = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset req_ready",  32'(req_ready),  32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_err",   32'(resp_err),   32'd0);
    check("reset resp_rdata", resp_rdata,      32'h0);
    check("reset dbg_byte1",  32'(dbg_byte1),  32'h0);

    for (int i = 0; i < 26; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 2, tag, rd, er);
      check({tag, " rdata"},     rd,               vecs[i].exp_rdata);
      check({tag, " err"},       32'(er),          32'(vecs[i].exp_err));
      check({tag, " dbg_byte1"}, 32'(dbg_byte1),   32'(vecs[i].exp_dbg));
    end

    // backpressure: response held 3 cycles while a new request waits on req_valid
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h004; req_wdata = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!resp_valid && n < 20);
      check("bp latency", 32'(n), 32'd2);
      req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h005;
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        check($sformatf("bp c%0d resp_valid", c), 32'(resp_valid), 32'd1);
        check($sformatf("bp c%0d rdata", c),      resp_rdata,      32'h1155_3344);
        check($sformatf("bp c%0d err", c),        32'(resp_err),   32'd0);
        check($sformatf("bp c%0d req_ready", c),  32'(req_ready),  32'd0);
      end
      @(negedge clk);
      check("bp c3 resp_valid", 32'(resp_valid), 32'd1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("bp bubble req_ready",  32'(req_ready),  32'd1);
      check("bp bubble resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!resp_valid && n < 20);
      check("bp next latency", 32'(n), 32'd2);
      check("bp next rdata", resp_rdata, 32'h0000_0033);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end

    // reset in the 2nd WAIT cycle of a LATENCY=4 store must abort it completely
    @(negedge clk);
    sel = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h000; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (resp_valid) pulses++;
    @(negedge clk);
    if (resp_valid) pulses++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort resp_valid pulses", 32'(pulses), 32'd0);
    check("abort req_ready",         32'(req_ready), 32'd1);
    check("reset clears A byte1",    32'(a_dbg_byte1), 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 4, "abort lw", rd, er);
    check("abort lw rdata", rd,      32'h0);
    check("abort lw err",   32'(er), 32'd0);
    do_req(1'b1, 2'd0, 1'b0, 32'h001, 32'h0000_005C, 4, "lat4 sb", rd, er);
    check("lat4 dbg_byte1", 32'(dbg_byte1), 32'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - DEPTH_BYTES, 256, data memory size in bytes.
  - LATENCY, 2, cycles from request accept to resp_valid; legal values are 1..15.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, single clock; all state updates on its rising edge.
  - rst, in, 1, reset, synchronous, active-high.
  - req_valid, in, 1, CPU load/store request present.
  - req_ready, out, 1, responder can accept a request.
  - req_we, in, 1, 1 = store, 0 = load.
  - req_size, in, 2, access size: 00 byte, 01 half, 10 word; 11 is illegal.
  - req_signed, in, 1, sign-extend byte/half loads (lb/lh); 0 zero-extends (lbu/lhu).
  - req_addr, in, 32, byte address.
  - req_wdata, in, 32, store data, right-aligned.
  - resp_valid, out, 1, response present.
  - resp_ready, in, 1, CPU accepts response.
  - resp_rdata, out, 32, load data; 0 for stores and errors.
  - resp_err, out, 1, request was misaligned, out of range or of illegal size.
  - dbg_byte1, out, 8, live copy of memory byte address 1, for bench observation.

Function
REQ-003 FSM states are IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 Accept occurs on the cycle where req_valid && req_ready. All request fields SHALL be latched at accept; later input changes have no effect.
REQ-005 On accept, if LATENCY == 1 the FSM goes to RESP; otherwise it goes to WAIT with a 4-bit down-counter loaded with LATENCY-2.
REQ-006 WAIT decrements the counter each cycle and goes to RESP when the counter is 0. resp_valid therefore rises exactly LATENCY cycles after the accept edge.
REQ-007 Error conditions, checked on the latched request. Any one of these sets the error flag:
  - req_size == 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr + size_bytes - 1 >= DEPTH_BYTES.
REQ-008 An erroring request SHALL follow the same latency, SHALL give resp_err=1 and resp_rdata=0, and SHALL NOT modify memory.
REQ-009 Store commit: memory is written on the edge of the WAIT/IDLE->RESP transition, little-endian.
  - Byte stores write wdata[7:0].
  - Half stores write wdata[15:0].
  - Word stores write all 32 bits.
  - Only the addressed bytes change.
REQ-010 Load data is captured on that same edge, little-endian. Byte and half results are sign- or zero-extended per req_signed; word results are unmodified.
REQ-011 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready. The FSM then goes to IDLE, giving one bubble cycle before the next accept.
REQ-012 resp_valid SHALL be 0 in IDLE and WAIT; at most one request is outstanding.
REQ-013 dbg_byte1 is combinational from memory byte 1. It reflects a store in the cycle after commit.

Reset
REQ-014 rst=1 at a clock edge SHALL force the following, regardless of state:
  - FSM to IDLE, counter to 0, latched request cleared;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - req_ready=1 from the next cycle;
  - all memory bytes to 0, so dbg_byte1=0.
REQ-015 rst asserted during WAIT SHALL abort the pending store with no partial write. Reset has priority over a simultaneous accept or commit.

Verification
REQ-016 Reset: hold rst 2 cycles, then release. Required: req_ready=1, resp_valid=0, resp_err=0, dbg_byte1=0x00.
REQ-017 Word store/load: sw 0x11223344 to 0x04, then lw from 0x04. Required:
  - resp_valid high exactly 2 cycles after each accept;
  - load returns 0x11223344 with resp_err=0;
  - lbu from 0x05 returns 0x00000033.
REQ-018 Byte store and extension: sb 0xAB to 0x01. Required:
  - dbg_byte1=0xAB;
  - lb from 0x01 returns 0xFFFFFFAB;
  - lbu from 0x01 returns 0x000000AB;
  - lh from 0x00 returns 0xFFFFAB00.
REQ-019 Errors:
  - lh from 0x03 gives resp_err=1, rdata=0;
  - sw to 0xFC with DEPTH_BYTES=256 succeeds;
  - sw to 0x100 gives resp_err=1;
  - a following lw from 0xFC shows the first value unchanged.
REQ-020 Backpressure: hold resp_ready=0 for 3 cycles. Required: resp_valid, rdata and err stable, and req_ready=0 throughout. After the handshake, the next req_valid is accepted exactly 1 cycle later.
REQ-021 Reset mid-operation: sw 0xDEADBEEF to 0x00 with LATENCY=4; assert rst in the 2nd WAIT cycle. Required: lw from 0x00 after reset returns 0x00000000, and no resp_valid pulse occurs for the aborted request.
